vga_frame_ctrl: RTL and testbench

- Timing and frame controller that sequences the VGA pixel-colour datapath.
- Generates 640x480@60 sync timing, drives the pixel scan addresses (addr_h, addr_v), and pipeline-aligns hsync/vsync/de to the datapath's registered colour output.
- Snapshots game state into shadow registers only during vertical blank, so the map, cursor and screen state never change mid-frame (no tearing).

---
 rtl/vga_frame_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - VGA sync timing, scan addressing and vblank state snapshot
//
// Purpose: generates VGA sync timing (640x480@60 by default), drives the pixel
// scan address into the colour datapath, delays hsync/vsync/de to line up with
// the datapath's registered colour output, and copies game state into shadow
// registers only during vertical blank so a frame is never drawn from mixed state.
//
// Ports:
//   vga_clk, rst                  pixel clock, asynchronous active-high reset
//   map_i, map_shown_i, map_flag_i,
//   x_pos_i, y_pos_i, screen_state_i   live game state
//   upd_hold_i                    game logic mid-update, defer the snapshot
//   map_o .. screen_state_o       shadow copies of the live state
//   addr_h, addr_v                scan address, 12'hFFF outside the active window
//   hsync_o, vsync_o, de_o        active-low syncs and data enable, pipeline aligned
//   frame_start_o                 pulse when the counters sit at (0,0)
//   snap_o                        pulse in the cycle the shadow registers change
//   miss_cnt_o                    saturating count of frames with no snapshot
module vga_frame_ctrl #(
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int PIPE_DELAY = 2,
    parameter int MAP_BITS   = 256,
    parameter int CELLS      = 64
) (
    input  logic                vga_clk,
    input  logic                rst,
    input  logic [MAP_BITS-1:0] map_i,
    input  logic [CELLS-1:0]    map_shown_i,
    input  logic [CELLS-1:0]    map_flag_i,
    input  logic [2:0]          x_pos_i,
    input  logic [2:0]          y_pos_i,
    input  logic [2:0]          screen_state_i,
    input  logic                upd_hold_i,
    output logic [MAP_BITS-1:0] map_o,
    output logic [CELLS-1:0]    map_shown_o,
    output logic [CELLS-1:0]    map_flag_o,
    output logic [2:0]          x_pos_o,
    output logic [2:0]          y_pos_o,
    output logic [2:0]          screen_state_o,
    output logic [11:0]         addr_h,
    output logic [11:0]         addr_v,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic                frame_start_o,
    output logic                snap_o,
    output logic [7:0]          miss_cnt_o
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
    localparam logic [11:0] H_START_C = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END_C   = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] V_START_C = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_END_C   = 12'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        active;
    logic        arm_point;
    logic        frame_first;
    logic        frame_last;

    logic        hs_raw;
    logic        vs_raw;
    logic        de_raw;
    logic [PIPE_DELAY-1:0] hs_dly;
    logic [PIPE_DELAY-1:0] vs_dly;
    logic [PIPE_DELAY-1:0] de_dly;

    logic [1:0]  state;

    assign h_last      = (h_cnt == H_LAST_C);
    assign v_last      = (v_cnt == V_LAST_C);
    assign active      = (h_cnt >= H_START_C) && (h_cnt < H_END_C) &&
                         (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    // first clock of the first line after the visible area
    assign arm_point   = (h_cnt == 12'd0) && (v_cnt == V_END_C);
    assign frame_first = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign frame_last  = h_last && v_last;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (h_last) begin
            h_cnt <= 12'd0;
            v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Address, raw sync/enable and frame_start share one register stage so
    // they all describe the same counter position.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            addr_h        <= 12'hFFF;
            addr_v        <= 12'hFFF;
            hs_raw        <= 1'b1;
            vs_raw        <= 1'b1;
            de_raw        <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            if (active) begin
                addr_h <= h_cnt - H_START_C;
                addr_v <= v_cnt - V_START_C;
            end else begin
                addr_h <= 12'hFFF;
                addr_v <= 12'hFFF;
            end
            hs_raw        <= !(h_cnt < H_SYNC_C);
            vs_raw        <= !(v_cnt < V_SYNC_C);
            de_raw        <= active;
            frame_start_o <= frame_first;
        end
    end

    // Delay line matching the colour datapath latency from address to rgb.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hs_dly <= '1;
            vs_dly <= '1;
            de_dly <= '0;
        end else begin
            hs_dly[0] <= hs_raw;
            vs_dly[0] <= vs_raw;
            de_dly[0] <= de_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_dly[i] <= hs_dly[i-1];
                vs_dly[i] <= vs_dly[i-1];
                de_dly[i] <= de_dly[i-1];
            end
        end
    end

    assign hsync_o = hs_dly[PIPE_DELAY-1];
    assign vsync_o = vs_dly[PIPE_DELAY-1];
    assign de_o    = de_dly[PIPE_DELAY-1];

    // Snapshot sequencer: arms at the start of vertical blank, captures on the
    // first clock the game logic is not mid-update, and gives up (counting a
    // miss) if the hold is still asserted on the last clock of the frame.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            snap_o         <= 1'b0;
            miss_cnt_o     <= 8'd0;
            map_o          <= '0;
            map_shown_o    <= '0;
            map_flag_o     <= '0;
            x_pos_o        <= 3'd0;
            y_pos_o        <= 3'd0;
            screen_state_o <= 3'd0;
        end else begin
            snap_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm_point) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!upd_hold_i) begin
                        map_o          <= map_i;
                        map_shown_o    <= map_shown_i;
                        map_flag_o     <= map_flag_i;
                        x_pos_o        <= x_pos_i;
                        y_pos_o        <= y_pos_i;
                        screen_state_o <= screen_state_i;
                        snap_o         <= 1'b1;
                        state          <= ST_DONE;
                    end else if (frame_last) begin
                        if (miss_cnt_o != 8'hFF) begin
                            miss_cnt_o <= miss_cnt_o + 8'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (frame_first) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb/tb_vga_frame_ctrl.sv - randomized self-checking bench for vga_frame_ctrl
module tb_vga_frame_ctrl;

    localparam int HS = 4, HB = 3, HA = 10, HF = 2;
    localparam int VS = 2, VB = 2, VA = 5, VF = 2;
    localparam int PD = 2;
    localparam int HT = HS + HB + HA + HF;           // 19
    localparam int VT = VS + VB + VA + VF;           // 11
    localparam int FRAME = HT * VT;                  // 209
    localparam int ARM_P = (VS + VB + VA) * HT;      // 171

    logic         vga_clk;
    logic         rst;
    logic [255:0] map_i;
    logic [63:0]  map_shown_i;
    logic [63:0]  map_flag_i;
    logic [2:0]   x_pos_i;
    logic [2:0]   y_pos_i;
    logic [2:0]   screen_state_i;
    logic         upd_hold_i;
    logic [255:0] map_o;
    logic [63:0]  map_shown_o;
    logic [63:0]  map_flag_o;
    logic [2:0]   x_pos_o;
    logic [2:0]   y_pos_o;
    logic [2:0]   screen_state_o;
    logic [11:0]  addr_h;
    logic [11:0]  addr_v;
    logic         hsync_o;
    logic         vsync_o;
    logic         de_o;
    logic         frame_start_o;
    logic         snap_o;
    logic [7:0]   miss_cnt_o;

    int total = 0;
    int bad = 0;
    int mode = 0;

    vga_frame_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .PIPE_DELAY(PD), .MAP_BITS(256), .CELLS(64)
    ) dut (
        .vga_clk(vga_clk), .rst(rst),
        .map_i(map_i), .map_shown_i(map_shown_i), .map_flag_i(map_flag_i),
        .x_pos_i(x_pos_i), .y_pos_i(y_pos_i), .screen_state_i(screen_state_i),
        .upd_hold_i(upd_hold_i),
        .map_o(map_o), .map_shown_o(map_shown_o), .map_flag_o(map_flag_o),
        .x_pos_o(x_pos_o), .y_pos_o(y_pos_o), .screen_state_o(screen_state_o),
        .addr_h(addr_h), .addr_v(addr_v),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .frame_start_o(frame_start_o), .snap_o(snap_o), .miss_cnt_o(miss_cnt_o)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // n = index of the clock edge since reset release (-1 while in reset).
    // The counters at edge n sit at position n of an endless raster scan.
    int           n;
    logic         captured;
    logic         m_snap;
    logic [7:0]   m_miss;
    logic [255:0] m_map;
    logic [63:0]  m_shown, m_flag;
    logic [2:0]   m_x, m_y, m_scr;

    function automatic int f_h(input int q);
        return q % HT;
    endfunction
    function automatic int f_v(input int q);
        return (q / HT) % VT;
    endfunction
    function automatic bit f_act(input int q);
        return q >= 0 && f_h(q) >= HS + HB && f_h(q) < HS + HB + HA &&
               f_v(q) >= VS + VB && f_v(q) < VS + VB + VA;
    endfunction

    always @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            n        <= -1;
            captured <= 1'b0;
            m_snap   <= 1'b0;
            m_miss   <= 8'd0;
            m_map    <= '0;
            m_shown  <= '0;
            m_flag   <= '0;
            m_x      <= 3'd0;
            m_y      <= 3'd0;
            m_scr    <= 3'd0;
        end else begin
            n      <= n + 1;
            m_snap <= 1'b0;
            if ((n + 1) % FRAME == 0)
                captured <= 1'b0;
            // capture window: after the arm edge up to and including the last edge
            if (((n + 1) % FRAME) > ARM_P && !captured) begin
                if (!upd_hold_i) begin
                    captured <= 1'b1;
                    m_snap   <= 1'b1;
                    m_map    <= map_i;
                    m_shown  <= map_shown_i;
                    m_flag   <= map_flag_i;
                    m_x      <= x_pos_i;
                    m_y      <= y_pos_i;
                    m_scr    <= screen_state_i;
                end else if (((n + 1) % FRAME) == FRAME - 1) begin
                    if (m_miss != 8'd255)
                        m_miss <= m_miss + 8'd1;
                end
            end
        end
    end

    always @(negedge vga_clk) begin
        check("addr_h", addr_h, f_act(n) ? 12'(f_h(n) - (HS + HB)) : 12'hFFF);
        check("addr_v", addr_v, f_act(n) ? 12'(f_v(n) - (VS + VB)) : 12'hFFF);
        check("frame_start", frame_start_o, n >= 0 && n % FRAME == 0);
        check("hsync", hsync_o, (n - PD < 0) ? 1'b1 : (f_h(n - PD) >= HS));
        check("vsync", vsync_o, (n - PD < 0) ? 1'b1 : (f_v(n - PD) >= VS));
        check("de", de_o, f_act(n - PD));
        check("snap", snap_o, m_snap);
        check("miss_cnt", miss_cnt_o, m_miss);
        check("map_o", map_o, m_map);
        check("map_shown_o", map_shown_o, m_shown);
        check("map_flag_o", map_flag_o, m_flag);
        check("cursor", {x_pos_o, y_pos_o}, {m_x, m_y});
        check("screen_state_o", screen_state_o, m_scr);
    end

    // ---------------- input driver ----------------
    initial begin
        map_i = '0; map_shown_i = '0; map_flag_i = '0;
        x_pos_i = 3'd0; y_pos_i = 3'd0; screen_state_i = 3'd0; upd_hold_i = 1'b0;
        forever begin
            @(posedge vga_clk);
            #1;
            for (int i = 0; i < 8; i++) map_i[i*32 +: 32] = $urandom();
            map_shown_i    = {$urandom(), $urandom()};
            map_flag_i     = {$urandom(), $urandom()};
            x_pos_i        = 3'($urandom_range(0, 7));
            y_pos_i        = 3'($urandom_range(0, 7));
            screen_state_i = 3'($urandom_range(0, 7));
            case (mode)
                1: upd_hold_i = ((n + 1) % FRAME) > ARM_P && ((n + 1) % FRAME) <= ARM_P + 30;
                2: upd_hold_i = 1'b1;
                3: upd_hold_i = ((n + 1) % FRAME) != FRAME - 1;
                4: upd_hold_i = $urandom_range(0, 7) != 0;
                default: upd_hold_i = 1'b0;
            endcase
        end
    end

    // One frame from frame_start_o: period, sync/enable counts, de rise and snap offsets.
    task automatic measure(input int exp_snap, input int exp_wait);
        int waits = 0, hs = 0, vs = 0, de = 0, de_rise = -1, snap_off = -1;
        while (!frame_start_o && waits < FRAME + 4) begin
            @(negedge vga_clk);
            waits++;
        end
        if (exp_wait >= 0) check("fs_wait", waits, exp_wait);
        for (int i = 0; i < FRAME; i++) begin
            if (!hsync_o) hs++;
            if (!vsync_o) vs++;
            if (de_o) de++;
            if (de_o && de_rise < 0) de_rise = i;
            if (snap_o) snap_off = i;
            @(negedge vga_clk);
        end
        check("fs_period", frame_start_o, 1'b1);
        check("hsync_low", hs, 44);
        check("vsync_low", vs, 38);
        check("de_high", de, 50);
        check("de_rise", de_rise, 85);
        if (exp_snap != -2) check("snap_off", snap_off, exp_snap);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        repeat (3) @(posedge vga_clk);
        #2;
        check("rst_addr_h", addr_h, 12'hFFF);
        check("rst_de", de_o, 1'b0);
        check("rst_hsync", hsync_o, 1'b1);
        check("rst_fs", frame_start_o, 1'b0);
        check("rst_miss", miss_cnt_o, 8'd0);
        check("rst_map", map_o, 256'd0);
        @(posedge vga_clk);
        #1 rst = 1'b0;
        @(negedge vga_clk);

        mode = 0; measure(172, 1);
        mode = 1; measure(202, 0);
        mode = 2; measure(-1, 0);
        check("miss_one", miss_cnt_o, 8'd1);
        mode = 3; measure(208, 0);
        check("miss_keep", miss_cnt_o, 8'd1);
        mode = 4;
        for (int f = 0; f < 4; f++) measure(-2, 0);
        mode = 2;
        for (int f = 0; f < 256; f++) measure(-1, 0);
        check("miss_sat", miss_cnt_o, 8'd255);

        // asynchronous reset in the middle of an active line
        mode = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge vga_clk);
            #2;
            if (n >= 0 && f_h(n) == 12 && f_act(n)) found = 1'b1;
        end
        check("rst_hit", found, 1'b1);
        check("pre_rst_de", de_o, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_addr_h", addr_h, 12'hFFF);
        check("mid_rst_addr_v", addr_v, 12'hFFF);
        check("mid_rst_de", de_o, 1'b0);
        check("mid_rst_syncs", {hsync_o, vsync_o}, 2'b11);
        check("mid_rst_miss", miss_cnt_o, 8'd0);
        check("mid_rst_shown", map_shown_o, 64'd0);
        repeat (2) @(posedge vga_clk);
        #1 rst = 1'b0;
        @(negedge vga_clk);
        measure(172, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
